ps2_mouse_pos: RTL and testbench
================================

# ps2_mouse_pos

Receive-only PS/2 mouse front end. It deglitches the mouse's `ps2_clk`/`ps2_data` lines, deframes 11-bit device-to-host frames and assembles 3-byte stream-mode movement packets. It integrates the signed deltas into clamped screen coordinates. The `xpos`/`ypos` outputs feed the cursor overlay stage of the VGA pipeline. Data reporting is enabled by a separate init block; this block never drives the PS/2 lines.

## Interface

Parameters:

- `FILTER_LEN`, 8: consecutive equal samples required before the filtered `ps2_clk` changes.
- `TIMEOUT_CYC`, 40000: idle cycles mid-frame before abort (1 ms at 40 MHz).
- `X_MAX`, 799: maximum `xpos`.
- `Y_MAX`, 599: maximum `ypos`.

Ports:

- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous
- `ps2_data`  in  1  raw PS/2 data, asynchronous
- `xpos`  out  12  cursor column, 0..X_MAX
- `ypos`  out  12  cursor row, 0..Y_MAX, row 0 at top
- `btn_left`, `btn_right`, `btn_middle`  out  1 each  button state from the last accepted packet
- `new_event`  out  1  one-cycle pulse when position and buttons update
- `frame_err`  out  1  one-cycle pulse on a rejected frame or a timeout

## Operation

**Input conditioning**
- Both inputs pass through 2-FF synchronizers.
- The filtered clock takes the synchronized value only after FILTER_LEN identical consecutive samples.
- A falling edge of the filtered clock produces a one-cycle `fall` strobe. Data is sampled (synchronized `ps2_data`) on `fall`.

**Frame FSM: IDLE → RECV → CHECK → IDLE**
- IDLE: on `fall`, store the start bit, set bit_cnt=1 and go to RECV.
- RECV: on each `fall`, shift in data LSB first, then parity, then stop. When bit_cnt reaches 11, go to CHECK.
- A frame is valid when start=0, stop=1, and the parity over 8 data bits plus the parity bit is odd.
- CHECK (one cycle): a valid frame raises `byte_valid` for one cycle. An invalid frame pulses `frame_err`, drops the byte and resets pkt_idx to 0.
- Timeout: in RECV, an idle counter clears on each `fall`. When it reaches TIMEOUT_CYC, pulse `frame_err`, return to IDLE and reset bit_cnt and pkt_idx to 0.

**Packet assembly (pkt_idx 0..2)**
- byte0 = {Yovf, Xovf, Ysign, Xsign, 1, M, R, L}.
  - With pkt_idx=0, a byte with bit3=0 is discarded silently and pkt_idx stays 0. This is the resync rule.
- byte1 = X[7:0], byte2 = Y[7:0]. Accepting byte2 completes the packet and resets pkt_idx to 0.
- dx = signed {Xsign, byte1}; dy = signed {Ysign, byte2}, each 9 bits. If an axis overflow bit is set, that axis delta is 0; buttons still update.

**Position update (one cycle after byte2 is accepted)**
- x_next = xpos + sext13(dx), computed as a 13-bit signed value and clamped to [0, X_MAX].
- y_next = ypos − sext13(dy), clamped to [0, Y_MAX]. PS/2 +Y means up; the screen's +Y is down.
- `xpos`, `ypos` and the buttons register simultaneously, and `new_event` pulses in the same cycle.

**Reset**
- Resets all state, including mid-frame and mid-packet.
- FSM goes to IDLE; bit_cnt, pkt_idx and the idle counter go to 0.
- Filtered clock resets to 1.
- Outputs reset to: `xpos`=0, `ypos`=0, all buttons 0, `new_event`=0, `frame_err`=0.

## Timing

- Pin-to-`fall` latency: 2 sync cycles + FILTER_LEN + 1 cycles.
- Stop-bit `fall` at cycle T: CHECK at T+1, so `byte_valid` or `frame_err` appears at T+1.
- For byte2, the outputs and `new_event` update at T+2.
- The block sustains back-to-back packets at any legal PS/2 rate (10–16.7 kHz) with clk ≥ 1 MHz.
- `new_event` and `frame_err` never assert in the same cycle. Each is high for exactly one cycle.
- Between updates, outputs hold their values.

## Test plan

- **Reset:** assert `rst` mid-frame (after 5 bits), then deassert and send packet 08,0A,00. Required: all outputs 0 during reset, no pulses, then `xpos`=10, `ypos`=0 and one `new_event`.
- **Sign, Y inversion, low clamp:** from (10,0) send 28,00,FB (dy=−5), giving `ypos`=5. Then send 18,80,00 (dx=−128), giving `xpos`=0 (clamped) with `ypos` unchanged.
- **High clamp and overflow:**
  - Eight packets of 08,7F,00 must leave `xpos`=799 after the 7th and 8th packets.
  - Packet 48,7F,00 (Xovf) must leave `xpos` unchanged and still pulse `new_event`.
- **Buttons:** packet 0F,00,00 sets left=right=middle=1 with `xpos`/`ypos` unchanged; packet 08,00,00 clears them.
- **Framing errors:** corrupt byte1 parity (and separately a stop bit of 0), then send a good packet.
  - Each corrupted frame produces one `frame_err` and no `new_event`.
  - The next good packet then decodes correctly.
  - A first byte of 00 is ignored without an error.
- **Filter and timeout:**
  - 3-cycle glitches on `ps2_clk` during a frame leave the decode unaffected.
  - 5 bits followed by TIMEOUT_CYC+10 idle cycles produce one `frame_err`, and the next packet 08,01,01 yields a +1/−1 update.

Source files
------------

// File: rtl/ps2_mouse_pos.sv
// ps2_mouse_pos: receive-only PS/2 mouse front end.
// Deglitches the PS/2 lines, deframes 11-bit device-to-host frames,
// assembles 3-byte stream-mode packets and integrates the signed deltas
// into screen coordinates clamped to [0, X_MAX] x [0, Y_MAX].
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ps2_clk, ps2_data raw asynchronous PS/2 lines (never driven here)
//   xpos, ypos        cursor position, row 0 at top
//   btn_left/right/middle  button state from the last accepted packet
//   new_event         one-cycle pulse when position/buttons update
//   frame_err         one-cycle pulse on a rejected frame or a timeout
module ps2_mouse_pos #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 40000,
  parameter int unsigned X_MAX       = 799,
  parameter int unsigned Y_MAX       = 599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_middle,
  output logic        new_event,
  output logic        frame_err
);

  localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned POS_W = 12;
  localparam int unsigned SUM_W = 13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // Input synchronizers
  logic clk_s1, clk_s2, data_s1, data_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Clock filter: the filtered level follows only after FILTER_LEN
  // consecutive samples that disagree with it; any agreeing sample restarts.
  logic          clk_f;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_f    <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == clk_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f    <= clk_s2;
        filt_cnt <= '0;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM
  state_t        state, state_next;
  logic [10:0]   sr;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] idle_cnt;
  logic          byte_valid;
  logic [10:0]   sr_shift_c;
  logic          start_c, shift_c, last_c, timeout_c, frame_ok_c;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    shift_c    = 1'b0;
    last_c     = 1'b0;
    timeout_c  = 1'b0;
    sr_shift_c = {data_s2, sr[10:1]};
    // Frame check on the value the register is about to hold, so the verdict
    // registers into the CHECK cycle itself.
    frame_ok_c = ~sr_shift_c[0] & sr_shift_c[10] & (^sr_shift_c[9:1]);
    case (state)
      S_IDLE: begin
        if (fall) begin
          start_c    = 1'b1;
          state_next = S_RECV;
        end
      end
      S_RECV: begin
        if (fall) begin
          shift_c = 1'b1;
          if (bit_cnt == 4'd10) begin
            last_c     = 1'b1;
            state_next = S_CHECK;
          end
        end else if (idle_cnt == TW'(TIMEOUT_CYC)) begin
          timeout_c  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_CHECK: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Frame datapath: shift register, bit counter, idle counter, verdicts
  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= last_c & frame_ok_c;
      frame_err  <= (last_c & ~frame_ok_c) | timeout_c;
      if (start_c || shift_c) sr <= sr_shift_c;

      if (start_c)                  bit_cnt <= 4'd1;
      else if (shift_c && !last_c)  bit_cnt <= bit_cnt + 4'd1;
      else if (state_next != S_RECV) bit_cnt <= '0;

      if (state == S_RECV && state_next == S_RECV && !fall)
        idle_cnt <= idle_cnt + TW'(1);
      else
        idle_cnt <= '0;
    end
  end

  // Packet assembly and position integration
  logic [7:0]             rx_byte;
  logic [1:0]             pkt_idx;
  logic [3:0]             hdr;      // {Yovf, Xovf, Ysign, Xsign}
  logic [2:0]             btn_pend; // {M, R, L}
  logic [7:0]             xbyte;
  logic signed [8:0]      dx_c, dy_c;
  logic signed [SUM_W-1:0] x_sum_c, y_sum_c;
  logic [POS_W-1:0]       x_next_c, y_next_c;

  assign rx_byte = sr[8:1];

  always_comb begin
    dx_c    = hdr[2] ? 9'sd0 : $signed({hdr[0], xbyte});
    dy_c    = hdr[3] ? 9'sd0 : $signed({hdr[1], rx_byte});
    x_sum_c = $signed({1'b0, xpos}) + SUM_W'(dx_c);
    // PS/2 +Y is up, screen +Y is down.
    y_sum_c = $signed({1'b0, ypos}) - SUM_W'(dy_c);

    if (x_sum_c < 0)                               x_next_c = '0;
    else if (x_sum_c > $signed(SUM_W'(X_MAX)))     x_next_c = POS_W'(X_MAX);
    else                                           x_next_c = x_sum_c[POS_W-1:0];

    if (y_sum_c < 0)                               y_next_c = '0;
    else if (y_sum_c > $signed(SUM_W'(Y_MAX)))     y_next_c = POS_W'(Y_MAX);
    else                                           y_next_c = y_sum_c[POS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_idx    <= '0;
      hdr        <= '0;
      btn_pend   <= '0;
      xbyte      <= '0;
      xpos       <= '0;
      ypos       <= '0;
      btn_left   <= 1'b0;
      btn_right  <= 1'b0;
      btn_middle <= 1'b0;
      new_event  <= 1'b0;
    end else begin
      new_event <= 1'b0;
      if (frame_err) begin
        pkt_idx <= '0;
      end else if (byte_valid) begin
        case (pkt_idx)
          2'd0: begin
            // Resync: only a byte with the always-one bit set may start a packet.
            if (rx_byte[3]) begin
              hdr      <= rx_byte[7:4];
              btn_pend <= rx_byte[2:0];
              pkt_idx  <= 2'd1;
            end
          end
          2'd1: begin
            xbyte   <= rx_byte;
            pkt_idx <= 2'd2;
          end
          2'd2: begin
            xpos       <= x_next_c;
            ypos       <= y_next_c;
            btn_left   <= btn_pend[0];
            btn_right  <= btn_pend[1];
            btn_middle <= btn_pend[2];
            new_event  <= 1'b1;
            pkt_idx    <= 2'd0;
          end
          default: pkt_idx <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_pos.sv
// Randomized self-checking bench for ps2_mouse_pos against a packet-level
// reference model of cursor position and buttons.
module tb_ps2_mouse_pos;

  localparam int HALF  = 16;
  localparam int TO    = 1000;
  localparam int XMAX  = 799;
  localparam int YMAX  = 599;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [11:0] xpos, ypos;
  logic        btn_left, btn_right, btn_middle, new_event, frame_err;

  ps2_mouse_pos #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(TO),
    .X_MAX      (XMAX),
    .Y_MAX      (YMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .xpos      (xpos),
    .ypos      (ypos),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_middle(btn_middle),
    .new_event (new_event),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ev_cnt = 0, err_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
  logic ev_d = 1'b0, err_d = 1'b0;

  // Pulse monitor
  always @(negedge clk) begin
    if (new_event) ev_cnt <= ev_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (new_event && frame_err) overlap_cnt <= overlap_cnt + 1;
    if ((new_event && ev_d) || (frame_err && err_d)) wide_cnt <= wide_cnt + 1;
    ev_d  <= new_event;
    err_d <= frame_err;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while the clock is high, device pulls clock low.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    ps2_clk  = 1'b1;
    if (glitch) begin
      cyc(4);
      ps2_clk = 1'b0;
      cyc(3);
      ps2_clk = 1'b1;
      cyc(HALF - 7);
    end else begin
      cyc(HALF);
    end
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  // Reference model
  int xm = 0, ym = 0;
  logic [2:0] bm = 3'b000;

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    xm = clampi(xm + dx, XMAX);
    ym = clampi(ym - dy, YMAX);
    bm = b0[2:0];
  endtask

  task automatic check_state(input string tag);
    check({tag, "_x"}, int'(xpos), xm);
    check({tag, "_y"}, int'(ypos), ym);
    check({tag, "_btn"}, int'({btn_middle, btn_right, btn_left}), int'(bm));
  endtask

  task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input bit glitch, input string tag);
    int e0, r0;
    e0 = ev_cnt;
    r0 = err_cnt;
    send_frame(b0, 1'b0, 1'b0, glitch, 11);
    send_frame(b1, 1'b0, 1'b0, glitch, 11);
    send_frame(b2, 1'b0, 1'b0, glitch, 11);
    cyc(4);
    model_pkt(b0, b1, b2);
    check_state(tag);
    check({tag, "_ev"}, ev_cnt - e0, 1);
    check({tag, "_err"}, err_cnt - r0, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int e0, r0;
    logic [7:0] b0, b1, b2;

    // Reset state
    rst = 1'b1;
    cyc(5);
    check_state("rst0");
    check("rst0_pulses", int'(new_event) + int'(frame_err), 0);
    rst = 1'b0;
    cyc(20);

    // Reset in mid-frame, then first packet
    send_frame(8'h08, 1'b0, 1'b0, 1'b0, 5);
    rst = 1'b1;
    cyc(3);
    check_state("rst_mid");
    cyc(3);
    rst = 1'b0;
    cyc(20);
    check("rst_no_pulse", ev_cnt + err_cnt, 0);
    pkt(8'h08, 8'h0A, 8'h00, 1'b0, "first");

    // Sign, Y inversion, low clamp
    pkt(8'h28, 8'h00, 8'hFB, 1'b0, "yneg");
    pkt(8'h18, 8'h80, 8'h00, 1'b0, "xclamp0");

    // High clamp and overflow
    for (int i = 0; i < 8; i++) pkt(8'h08, 8'h7F, 8'h00, 1'b0, "xhigh");
    pkt(8'h48, 8'h7F, 8'h00, 1'b0, "xovf");

    // Buttons
    pkt(8'h0F, 8'h00, 8'h00, 1'b0, "btn_set");
    pkt(8'h08, 8'h00, 8'h00, 1'b0, "btn_clr");

    // Bad parity on byte1
    e0 = ev_cnt; r0 = err_cnt;
    send_frame(8'h08, 1'b0, 1'b0, 1'b0, 11);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 11);
    cyc(4);
    check("par_err", err_cnt - r0, 1);
    check("par_ev", ev_cnt - e0, 0);
    pkt(8'h28, 8'hF6, 8'h05, 1'b0, "after_par");

    // Stop bit of 0 on byte1
    e0 = ev_cnt; r0 = err_cnt;
    send_frame(8'h08, 1'b0, 1'b0, 1'b0, 11);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 11);
    cyc(4);
    check("stop_err", err_cnt - r0, 1);
    check("stop_ev", ev_cnt - e0, 0);
    pkt(8'h08, 8'h05, 8'h00, 1'b0, "after_stop");

    // Resync: a leading 00 is dropped silently
    e0 = ev_cnt; r0 = err_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 11);
    cyc(4);
    check("resync_err", err_cnt - r0, 0);
    check("resync_ev", ev_cnt - e0, 0);
    pkt(8'h08, 8'h03, 8'h00, 1'b0, "after_resync");

    // Glitches on ps2_clk during every bit
    pkt(8'h09, 8'h02, 8'h01, 1'b1, "glitch");

    // Mid-frame timeout
    e0 = ev_cnt; r0 = err_cnt;
    send_frame(8'h08, 1'b0, 1'b0, 1'b0, 5);
    cyc(TO + 10);
    check("to_err", err_cnt - r0, 1);
    check("to_ev", ev_cnt - e0, 0);
    pkt(8'h08, 8'h01, 8'h01, 1'b0, "after_to");

    // Randomized packets
    for (int i = 0; i < 24; i++) begin
      b0 = 8'($urandom_range(0, 255));
      b0[3] = 1'b1;
      b0[7] = ($urandom_range(0, 7) == 0);
      b0[6] = ($urandom_range(0, 7) == 0);
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      pkt(b0, b1, b2, 1'b0, "rand");
    end

    cyc(4);
    check("pulse_overlap", overlap_cnt, 0);
    check("pulse_width", wide_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
